serial_uart_bridge: RTL

Byte-oriented UART bridge between the processor's memory-mapped serial port (the `serial_*` signals of `data_memory`) and a pair of external RX/TX pins. Incoming UART frames are deserialized into an RX FIFO that the processor drains through a valid/read-enable handshake. Processor writes are buffered in a TX FIFO and serialized onto the TX pin as 8N1 frames. It sits directly outside the processor, driving `serial_in`, `serial_valid_in` and `serial_ready_in`, and consuming `serial_out`, `serial_rden_out` and `serial_wren_out`.

---
 rtl/serial_uart_bridge_if.sv | 20 ++
 rtl/serial_uart_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_uart_bridge_if.sv
// Processor-side serial port of the UART bridge: RX FIFO head/valid, TX FIFO ready,
// and the processor's write data with its read/write strobes.
interface serial_uart_bridge_if;
    logic [7:0] serial_in;
    logic       serial_valid_in;
    logic       serial_ready_in;
    logic [7:0] serial_out;
    logic       serial_rden_out;
    logic       serial_wren_out;

    modport master (
        input  serial_in, serial_valid_in, serial_ready_in,
        output serial_out, serial_rden_out, serial_wren_out
    );

    modport slave (
        output serial_in, serial_valid_in, serial_ready_in,
        input  serial_out, serial_rden_out, serial_wren_out
    );
endinterface

// File: rtl/serial_uart_bridge.sv
// UART bridge: 8N1 receiver and transmitter, each buffered by a show-ahead byte FIFO,
// exposed to the processor through serial_uart_bridge_if.
module serial_uart_bridge_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               push_ok;
    logic               pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (FIFO_AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    // Empty FIFO presents zero rather than a stale memory word.
    assign rdata   = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

module serial_uart_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_uart_bridge_if.slave  bus,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic                 err_clear,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
    output logic                 tx_busy
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    rx_state_t     rx_state, rx_state_n;
    logic          rx_meta, rx_sync;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_push, overrun_set, frame_set;
    logic          rx_empty, rx_full;

    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_line, tx_line_n;
    logic          tx_pop;
    logic [7:0]    tx_head;
    logic          tx_empty, tx_full;

    serial_uart_bridge_fifo #(.FIFO_AW(FIFO_AW)) rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .wdata (rx_shift),
        .pop   (bus.serial_rden_out),
        .rdata (bus.serial_in),
        .empty (rx_empty),
        .full  (rx_full)
    );

    serial_uart_bridge_fifo #(.FIFO_AW(FIFO_AW)) tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (bus.serial_wren_out),
        .wdata (bus.serial_out),
        .pop   (tx_pop),
        .rdata (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    assign bus.serial_valid_in = !rx_empty;
    assign bus.serial_ready_in = !tx_full;
    assign uart_tx             = tx_line;
    assign tx_busy             = (tx_state != TX_IDLE) || !tx_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
        end
        rx_shift <= rx_shift_n;
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt + 1'b1;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_push     = 1'b0;
        overrun_set = 1'b0;
        frame_set   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                if (!rx_sync) rx_state_n = RX_START;
            end
            RX_START: begin
                // A start bit that is no longer low at its midpoint is treated as noise.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    if (!rx_sync)     frame_set   = 1'b1;
                    else if (rx_full) overrun_set = 1'b1;
                    else              rx_push     = 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // Error flags are set-dominant over err_clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (overrun_set)    rx_overrun <= 1'b1;
            else if (err_clear) rx_overrun <= 1'b0;
            if (frame_set)      rx_frame_err <= 1'b1;
            else if (err_clear) rx_frame_err <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_line  <= tx_line_n;
        end
        tx_shift <= tx_shift_n;
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                tx_bit_n = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = tx_bit + 3'd1;
                    tx_shift_n = {1'b1, tx_shift[7:1]};
                    if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        // The pin is registered from the next state so it never glitches on decode.
        if (tx_state_n == TX_START)     tx_line_n = 1'b0;
        else if (tx_state_n == TX_DATA) tx_line_n = tx_shift_n[0];
        else                            tx_line_n = 1'b1;
    end
endmodule
